// File: rtl/si5338_init_seq.sv
// Table-driven Si5338 init sequencer: fetches WRITE/RMW/POLL/END entries and runs them over the USR_* I2C master handshake.
// START to first USR_trig is 3 cycles; each transfer stalls until USR_end. SI5338_INIT_AUTOSTART_EN: start on reset release.
module si5338_init_seq #(
   parameter logic [7:0]  DEV_ID    = 8'h70,
   parameter int          TBL_AW    = 9,
   parameter int          RETRY_MAX = 3,
   parameter logic [15:0] POLL_MAX  = 16'd1000,
   parameter logic [15:0] POLL_GAP  = 16'd2000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic [TBL_AW-1:0] TBL_ADDR,
   input  logic [31:0]       TBL_DATA,
   output logic              USR_trig,
   output logic              USR_rnw,
   output logic [7:0]        USR_wrcyc,
   output logic [7:0]        USR_rdcyc,
   output logic [7:0]        USR_deivce_id,
   output logic [15:0]       USR_reg_addr,
   input  logic              USR_wvld,
   output logic [7:0]        USR_wdata,
   input  logic              USR_rvld,
   input  logic [7:0]        USR_rdata,
   input  logic              USR_error,
   input  logic              USR_end,
   output logic              BUSY,
   output logic              DONE,
   output logic              FAIL,
   output logic [TBL_AW-1:0] FAIL_IDX,
   output logic [1:0]        FAIL_CODE
);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_RMW   = 2'b01;
   localparam logic [1:0] OP_POLL  = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_RD_TRIG, S_RD_WAIT, S_WR_TRIG,
      S_WR_WAIT, S_GAP, S_NEXT, S_FIN, S_ERR
   } state_t;

   typedef struct packed {
      logic [1:0] op;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] mask;
   } entry_t;

   state_t            state, state_nxt;
   entry_t            ent;
   logic [TBL_AW-1:0] idx;
   logic [7:0]        wbyte;
   logic [7:0]        rd;
   logic [7:0]        rd_now;
   logic [7:0]        retry_cnt;
   logic [15:0]       poll_cnt;
   logic [15:0]       gap_cnt;
   logic              start_eff;
   logic              retry_ok;
   logic              poll_hit;
   logic              poll_last;
   logic              gap_done;
   logic              unused_in;

`ifdef SI5338_INIT_AUTOSTART_EN
   logic auto_pend;

   always_ff @(posedge CLK) begin
      if (RST) auto_pend <= 1'b1;
      else     auto_pend <= 1'b0;
   end

   assign start_eff = START | auto_pend;
`else
   assign start_eff = START;
`endif

   // A read byte arriving with USR_end wins over any earlier captured byte
   assign rd_now    = USR_rvld ? USR_rdata : rd;
   assign retry_ok  = (32'(retry_cnt) < RETRY_MAX);
   assign poll_hit  = ((rd_now & ent.mask) == (ent.data & ent.mask));
   assign poll_last = (({1'b0, poll_cnt} + 17'd1) >= {1'b0, POLL_MAX});
   assign gap_done  = (({1'b0, gap_cnt} + 17'd1) >= {1'b0, POLL_GAP});
   assign unused_in = ^{USR_wvld, TBL_DATA[29:24]};

   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start_eff) state_nxt = S_FETCH;
         S_FETCH:   state_nxt = S_DECODE;
         S_DECODE: begin
            case (TBL_DATA[31:30])
               OP_WRITE:       state_nxt = S_WR_TRIG;
               OP_RMW, OP_POLL: state_nxt = S_RD_TRIG;
               default:        state_nxt = S_FIN;
            endcase
         end
         S_RD_TRIG: state_nxt = S_RD_WAIT;
         S_RD_WAIT: begin
            if (USR_end) begin
               if (USR_error)            state_nxt = retry_ok ? S_RD_TRIG : S_ERR;
               else if (ent.op == OP_RMW) state_nxt = S_WR_TRIG;
               else if (poll_hit)        state_nxt = S_NEXT;
               else if (poll_last)       state_nxt = S_ERR;
               else                      state_nxt = S_GAP;
            end
         end
         S_WR_TRIG: state_nxt = S_WR_WAIT;
         S_WR_WAIT: begin
            if (USR_end) begin
               if (USR_error) state_nxt = retry_ok ? S_WR_TRIG : S_ERR;
               else           state_nxt = S_NEXT;
            end
         end
         S_GAP:     if (gap_done) state_nxt = S_RD_TRIG;
         S_NEXT:    state_nxt = (idx == {TBL_AW{1'b1}}) ? S_FIN : S_FETCH;
         S_FIN:     state_nxt = S_IDLE;
         S_ERR:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      USR_trig     = 1'b0;
      USR_rnw      = 1'b0;
      USR_wrcyc    = 8'd0;
      USR_rdcyc    = 8'd0;
      USR_reg_addr = 16'h0000;
      BUSY         = (state != S_IDLE);
      case (state)
         S_RD_TRIG, S_RD_WAIT: begin
            USR_trig     = (state == S_RD_TRIG);
            USR_rnw      = 1'b1;
            USR_rdcyc    = 8'd1;
            USR_reg_addr = {8'h00, ent.addr};
         end
         S_WR_TRIG, S_WR_WAIT: begin
            USR_trig     = (state == S_WR_TRIG);
            USR_wrcyc    = 8'd1;
            USR_reg_addr = {8'h00, ent.addr};
         end
         default: ;
      endcase
   end

   assign USR_wdata     = wbyte;
   assign USR_deivce_id = DEV_ID;
   assign TBL_ADDR      = idx;

   always_ff @(posedge CLK) begin
      if (RST) begin
         ent       <= '0;
         idx       <= '0;
         wbyte     <= 8'h00;
         rd        <= 8'h00;
         retry_cnt <= 8'd0;
         poll_cnt  <= 16'd0;
         gap_cnt   <= 16'd0;
         DONE      <= 1'b0;
         FAIL      <= 1'b0;
         FAIL_IDX  <= '0;
         FAIL_CODE <= 2'b00;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_eff) begin
                  DONE      <= 1'b0;
                  FAIL      <= 1'b0;
                  FAIL_IDX  <= '0;
                  FAIL_CODE <= 2'b00;
                  idx       <= '0;
               end
            end
            S_DECODE: begin
               ent       <= {TBL_DATA[31:30], TBL_DATA[23:0]};
               retry_cnt <= 8'd0;
               poll_cnt  <= 16'd0;
               if (TBL_DATA[31:30] == OP_WRITE) wbyte <= TBL_DATA[15:8];
            end
            S_RD_WAIT: begin
               if (USR_rvld) rd <= USR_rdata;
               if (USR_end) begin
                  if (USR_error) begin
                     if (retry_ok) retry_cnt <= retry_cnt + 8'd1;
                     else          FAIL_CODE <= 2'b01;
                  end else if (ent.op == OP_RMW) begin
                     wbyte <= (rd_now & ~ent.mask) | (ent.data & ent.mask);
                  end else if (!poll_hit) begin
                     poll_cnt <= poll_cnt + 16'd1;
                     gap_cnt  <= 16'd0;
                     if (poll_last) FAIL_CODE <= 2'b10;
                  end
               end
            end
            S_WR_WAIT: begin
               if (USR_end && USR_error) begin
                  if (retry_ok) retry_cnt <= retry_cnt + 8'd1;
                  else          FAIL_CODE <= 2'b01;
               end
            end
            S_GAP:  gap_cnt <= gap_cnt + 16'd1;
            S_NEXT: if (idx != {TBL_AW{1'b1}}) idx <= idx + 1'b1;
            S_FIN:  DONE <= 1'b1;
            S_ERR: begin
               FAIL     <= 1'b1;
               FAIL_IDX <= idx;
            end
            default: ;
         endcase
      end
   end

endmodule
